decode_writeback: RTL and testbench
===================================

# decode_writeback

Decode/write-back stage of the sequential Y86-64 processor: the source and destination end of the register traffic around the execute stage. It maps `icode`/`rA`/`rB` to register IDs and drives `valA`/`valB` to execute. At the end of the cycle it commits execute's `valE` and memory's `valM` into the 15-entry register file, with conditional-move writes gated by execute's `Cnd`. It also keeps the sticky machine status (AOK/HLT/INS).

## Interface
Parameters:
- `NREG`, 15: architectural registers, IDs 0..14; ID 4'hF means RNONE.
- `W`, 64: data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icode`  in  4  current instruction code.
- `rA`  in  4  register specifier A.
- `rB`  in  4  register specifier B.
- `valE`  in  W  execute result, signed.
- `valM`  in  W  memory read result.
- `Cnd`  in  1  condition from execute; used only for icode 2.
- `wb_en`  in  1  write-back strobe; 1 = commit this instruction at the edge.
- `valA`  out  W  register[srcA], or 0 if srcA = RNONE.
- `valB`  out  W  register[srcB], or 0 if srcB = RNONE.
- `srcA`, `srcB`, `dstE`, `dstM`  out  4 each  decoded register IDs.
- `stat`  out  2  status: 0 = AOK, 1 = HLT, 2 = INS.
- `dbg_sel`  in  4  debug read select.
- `dbg_val`  out  W  register[dbg_sel], or 0 for 4'hF.

## Operation
Decode is combinational from `icode`/`rA`/`rB`. Reg numbers below are Y86 icodes in hex.

- srcA:
  - rA for icodes 2, 4, 6, A.
  - RSP (4) for icodes 9, B.
  - RNONE otherwise.
- srcB:
  - rB for icodes 4, 5, 6.
  - RSP for icodes 8, 9, A, B.
  - RNONE otherwise.
- dstE:
  - icode 2: rB if `Cnd`=1, else RNONE. Unconditional rrmovq (ifun 0) arrives with `Cnd`=1 from execute.
  - icodes 3, 6: rB.
  - icodes 8, 9, A, B: RSP.
  - RNONE otherwise.
- dstM: rA for icodes 5, B; RNONE otherwise.

Write-back happens at the rising edge when `wb_en`=1 and `stat`=AOK:
- reg[dstE] <= valE if dstE != F.
- reg[dstM] <= valM if dstM != F.
- If dstE == dstM (e.g. `popq %rsp`), valM wins.
- A register ID of 4'hF never writes.

Status:
- `wb_en`=1 with icode 0 sets `stat`=HLT. No register write occurs for that instruction.
- `wb_en`=1 with icode > 4'hB sets `stat`=INS. No register write occurs.
- Once `stat` != AOK, it is sticky. All further writes are suppressed until reset.

## Timing
- Reset (async, `rst_n`=0): all 15 registers clear to 0 and `stat` goes to AOK immediately. Consequently `valA`, `valB` and `dbg_val` read 0.
- Reset asserted mid-cycle discards the pending write. The first commit after release happens at the first rising edge with `rst_n`=1.
- Reads are combinational from current contents, with zero-cycle latency.
- Read-during-write returns the old value. The new value is visible after the edge; there is no bypass, per SEQ semantics.
- `wb_en`=0: no state change. Decode outputs still track the inputs.
- Write latency is 1 edge. `stat` updates at the same edge as the offending commit.
- Widths: `valE`/`valM` are stored verbatim at 64 bits; no sign extension or truncation.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - RSP=4, RNONE=4'hF.
  - stat codes SAOK/SHLT/SINS.
  - This package is shared with fetch and execute.
- Sub-module `y86_regfile`:
  - NREG x W storage with async clear.
  - Two combinational read ports plus the debug port.
  - Two write ports with port M priority.
- Decode logic and the status register live in `decode_writeback`.

## Test plan
- Reset, then `irmovq $2,%rbx`: icode 3, rB=3, valE=2, `wb_en`=1.
  - Before the edge: `dstE`=3 and `dbg_val`(3)=0.
  - After the edge: `dbg_val`(3)=2.
- Conditional move, with r1=7 and r2=9 preloaded, icode 2, ifun 2, rA=1, rB=2:
  - `Cnd`=0 → `dstE`=F and r2 stays 9.
  - `Cnd`=1 → r2 becomes 7 after the edge.
- `popq %rsp`: icode B, rA=4, valE=0x108, valM=0x55. After the edge r4=0x55; the M-port priority holds.
- `OPq`, with r1=9223372036854775807 and r2=2, icode 6, rA=1, rB=2:
  - `valA`=9223372036854775807 and `valB`=2.
  - valE=-9223372036854775807 is stored in r2 unchanged.
- `halt`, then `irmovq $5,%rax`, both with `wb_en`=1:
  - `stat`=HLT after the first edge.
  - r0 stays 0.
  - Asserting `rst_n`=0 mid-cycle clears `stat` to AOK immediately.
- icode 4'hD with `wb_en`=1 → `stat`=INS. A subsequent write to r5 is suppressed; r5 stays 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and types used by fetch, execute and decode/write-back.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        SAOK = 2'd0,
        SHLT = 2'd1,
        SINS = 2'd2
    } stat_t;

    typedef struct packed {
        logic [3:0] srcA;
        logic [3:0] srcB;
        logic [3:0] dstE;
        logic [3:0] dstM;
    } dec_t;

    function automatic logic icode_valid(input logic [3:0] ic);
        return ic <= IPOPQ;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// NREG x W register file: two read ports plus debug read, two write ports (M wins).
module y86_regfile #(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   srcA,
    input  logic [3:0]   srcB,
    input  logic [3:0]   dbg_sel,
    output logic [W-1:0] valA,
    output logic [W-1:0] valB,
    output logic [W-1:0] dbg_val,
    input  logic         weE,
    input  logic [3:0]   dstE,
    input  logic [W-1:0] valE,
    input  logic         weM,
    input  logic [3:0]   dstM,
    input  logic [W-1:0] valM
);

    logic [NREG-1:0][W-1:0] regs;

    // IDs with no matching entry (RNONE) fall through to zero.
    always_comb begin
        valA    = '0;
        valB    = '0;
        dbg_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i))    valA    = regs[i];
            if (srcB == 4'(i))    valB    = regs[i];
            if (dbg_sel == 4'(i)) dbg_val = regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (weM && dstM == 4'(i))      regs[i] <= valM;
                else if (weE && dstE == 4'(i)) regs[i] <= valE;
            end
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode/write-back: register ID decode, operand read, commit and sticky status.
module decode_writeback
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   icode,
    input  logic [3:0]   rA,
    input  logic [3:0]   rB,
    input  logic [W-1:0] valE,
    input  logic [W-1:0] valM,
    input  logic         Cnd,
    input  logic         wb_en,
    output logic [W-1:0] valA,
    output logic [W-1:0] valB,
    output logic [3:0]   srcA,
    output logic [3:0]   srcB,
    output logic [3:0]   dstE,
    output logic [3:0]   dstM,
    output logic [1:0]   stat,
    input  logic [3:0]   dbg_sel,
    output logic [W-1:0] dbg_val
);

    dec_t  dec;
    stat_t stat_q;
    logic  commit;

    always_comb begin
        dec = '{srcA: RNONE, srcB: RNONE, dstE: RNONE, dstM: RNONE};
        case (icode)
            IRRMOVQ: begin
                dec.srcA = rA;
                dec.dstE = Cnd ? rB : RNONE;
            end
            IIRMOVQ: dec.dstE = rB;
            IRMMOVQ: begin
                dec.srcA = rA;
                dec.srcB = rB;
            end
            IMRMOVQ: begin
                dec.srcB = rB;
                dec.dstM = rA;
            end
            IOPQ: begin
                dec.srcA = rA;
                dec.srcB = rB;
                dec.dstE = rB;
            end
            ICALL: begin
                dec.srcB = RSP;
                dec.dstE = RSP;
            end
            IRET: begin
                dec.srcA = RSP;
                dec.srcB = RSP;
                dec.dstE = RSP;
            end
            IPUSHQ: begin
                dec.srcA = rA;
                dec.srcB = RSP;
                dec.dstE = RSP;
            end
            IPOPQ: begin
                dec.srcA = RSP;
                dec.srcB = RSP;
                dec.dstE = RSP;
                dec.dstM = rA;
            end
            default: ;
        endcase
    end

    assign srcA = dec.srcA;
    assign srcB = dec.srcB;
    assign dstE = dec.dstE;
    assign dstM = dec.dstM;
    assign stat = stat_q;

    // halt and illegal instructions change status but never write registers
    assign commit = wb_en && (stat_q == SAOK) && (icode != IHALT) && icode_valid(icode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= SAOK;
        end else if (wb_en && stat_q == SAOK) begin
            if (icode == IHALT)          stat_q <= SHLT;
            else if (!icode_valid(icode)) stat_q <= SINS;
        end
    end

    y86_regfile #(.NREG(NREG), .W(W)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .srcA    (dec.srcA),
        .srcB    (dec.srcB),
        .dbg_sel (dbg_sel),
        .valA    (valA),
        .valB    (valB),
        .dbg_val (dbg_val),
        .weE     (commit && dec.dstE != RNONE),
        .dstE    (dec.dstE),
        .valE    (valE),
        .weM     (commit && dec.dstM != RNONE),
        .dstM    (dec.dstM),
        .valM    (valM)
    );

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: directed SEQ scenarios then random traffic.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  icode = 4'h1, rA = 4'hF, rB = 4'hF, dbg_sel = 4'hF;
    logic [63:0] valE = '0, valM = '0;
    logic        Cnd = 1'b0, wb_en = 1'b0;
    logic [63:0] valA, valB, dbg_val;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [1:0]  stat;

    decode_writeback dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB),
        .valE(valE), .valM(valM), .Cnd(Cnd), .wb_en(wb_en),
        .valA(valA), .valB(valB), .srcA(srcA), .srcB(srcB),
        .dstE(dstE), .dstM(dstM), .stat(stat),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  srcA, srcB, dstE, dstM;
        logic [63:0] valA, valB, dbg;
        logic [1:0]  stat;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0, n_bad = 0;
    logic [63:0] m_reg [15];
    logic [1:0]  m_stat;

    // Reference model: instruction-level register IDs and architectural state.
    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) return ra;
        if (ic == 4'h9 || ic == 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) return rb;
        if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb, input logic c);
        if (ic == 4'h2) return c ? rb : 4'hF;
        if (ic == 4'h3 || ic == 4'h6) return rb;
        if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
        return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
    endfunction

    function automatic logic [63:0] m_rd(input logic [3:0] r);
        return (r == 4'hF) ? 64'd0 : m_reg[r];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 15; i++) m_reg[i] = '0;
        m_stat = 2'd0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Drive one instruction, push its expected pre-edge view, then advance the model.
    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic c, input logic wb, input logic [3:0] ds);
        exp_t e;
        icode = ic; rA = ra; rB = rb; valE = ve; valM = vm; Cnd = c; wb_en = wb; dbg_sel = ds;
        e.srcA = m_srcA(ic, ra);
        e.srcB = m_srcB(ic, rb);
        e.dstE = m_dstE(ic, rb, c);
        e.dstM = m_dstM(ic, ra);
        e.valA = m_rd(e.srcA);
        e.valB = m_rd(e.srcB);
        e.dbg  = m_rd(ds);
        e.stat = m_stat;
        sb.push_back(e);
        if (wb && m_stat == 2'd0) begin
            if (ic == 4'h0) m_stat = 2'd1;
            else if (ic > 4'hB) m_stat = 2'd2;
            else begin
                if (e.dstE != 4'hF) m_reg[e.dstE] = ve;
                if (e.dstM != 4'hF) m_reg[e.dstM] = vm;
            end
        end
    endtask

    task automatic step(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic c, input logic wb, input logic [3:0] ds);
        @(posedge clk);
        #1;
        drive(ic, ra, rb, ve, vm, c, wb, ds);
    endtask

    task automatic peek(input logic [3:0] ds);
        step(4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 1'b0, ds);
    endtask

    // Reset asserted mid-cycle while a write is pending; the write must be dropped.
    task automatic mid_reset(input logic [3:0] ic, input logic [3:0] rb, input logic [63:0] ve);
        exp_t e;
        @(posedge clk);
        #1;
        icode = ic; rA = 4'hF; rB = rb; valE = ve; valM = '0; Cnd = 1'b1; wb_en = 1'b1;
        dbg_sel = rb;
        rst_n = 1'b0;
        m_clear();
        e.srcA = m_srcA(ic, 4'hF);
        e.srcB = m_srcB(ic, rb);
        e.dstE = m_dstE(ic, rb, 1'b1);
        e.dstM = m_dstM(ic, 4'hF);
        e.valA = 64'd0;
        e.valB = 64'd0;
        e.dbg  = 64'd0;
        e.stat = 2'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("srcA", 64'(srcA), 64'(e.srcA));
                chk("srcB", 64'(srcB), 64'(e.srcB));
                chk("dstE", 64'(dstE), 64'(e.dstE));
                chk("dstM", 64'(dstM), 64'(e.dstM));
                chk("valA", valA, e.valA);
                chk("valB", valB, e.valB);
                chk("dbg_val", dbg_val, e.dbg);
                chk("stat", 64'(stat), 64'(e.stat));
            end
        end
    end

    initial begin : stim
        logic [3:0] ic, ra, rb;
        m_clear();
        #2;
        mid_reset(4'h1, 4'hF, 64'd0);

        // irmovq $2,%rbx
        step(4'h3, 4'hF, 4'h3, 64'd2, 64'd0, 1'b1, 1'b1, 4'h3);
        peek(4'h3);

        // cmovXX with r1=7, r2=9
        step(4'h3, 4'hF, 4'h1, 64'd7, 64'd0, 1'b1, 1'b1, 4'h1);
        step(4'h3, 4'hF, 4'h2, 64'd9, 64'd0, 1'b1, 1'b1, 4'h2);
        step(4'h2, 4'h1, 4'h2, 64'd7, 64'd0, 1'b0, 1'b1, 4'h2);
        peek(4'h2);
        step(4'h2, 4'h1, 4'h2, 64'd7, 64'd0, 1'b1, 1'b1, 4'h2);
        peek(4'h2);

        // popq %rsp: M port wins over E port
        step(4'hB, 4'h4, 4'hF, 64'h108, 64'h55, 1'b1, 1'b1, 4'h4);
        peek(4'h4);

        // OPq at the signed extremes
        step(4'h3, 4'hF, 4'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1, 4'h1);
        step(4'h3, 4'hF, 4'h2, 64'd2, 64'd0, 1'b1, 1'b1, 4'h2);
        step(4'h6, 4'h1, 4'h2, 64'h8000_0000_0000_0001, 64'd0, 1'b1, 1'b1, 4'h2);
        peek(4'h2);

        // halt is sticky, then a mid-cycle reset drops a pending irmovq
        mid_reset(4'h1, 4'hF, 64'd0);
        step(4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b1, 1'b1, 4'h0);
        step(4'h3, 4'hF, 4'h0, 64'd5, 64'd0, 1'b1, 1'b1, 4'h0);
        peek(4'h0);
        mid_reset(4'h3, 4'h0, 64'd5);
        peek(4'h0);

        // illegal instruction then a suppressed write to r5
        step(4'hD, 4'hF, 4'hF, 64'd0, 64'd0, 1'b1, 1'b1, 4'h5);
        step(4'h3, 4'hF, 4'h5, 64'h77, 64'd0, 1'b1, 1'b1, 4'h5);
        peek(4'h5);

        // random legal traffic
        mid_reset(4'h1, 4'hF, 64'd0);
        for (int n = 0; n < 300; n++) begin
            ic = 4'($urandom_range(1, 11));
            ra = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            rb = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            step(ic, ra, rb, {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)));
        end
        peek(4'h4);

        repeat (2) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
